serial_add_ctrl: RTL and testbench

//  Sequencer that shares one 1-bit adder cell (two half adders + OR) across a WIDTH-bit addition.

---
 rtl/serial_add_pkg.sv | 27 ++
 rtl/serial_add_ctrl_if.sv | 30 +++
 rtl/fa_bit.sv | 36 +++
 rtl/ha_bit.sv | 15 +
 rtl/serial_add_ctrl.sv | 143 ++++++++++++++
 tb/tb_serial_add_ctrl.sv | 206 ++++++++++++++++++++
 6 files changed

// File: rtl/serial_add_pkg.sv
// serial_add_pkg
// Shared definitions for the bit-serial adder sequencer: state encoding,
// the legal WIDTH range and the counter sizing rule.
// No ports (package).

package serial_add_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // 2'd3 is never entered; the FSM decodes it as IDLE.
    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_e;

    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 32;

    // One spare bit so the count can reach WIDTH without wrapping.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if
// Operand/command and result bundle between the operand registers and the
// bit-serial adder sequencer.
//   start, clr, a, b, cin : requester -> sequencer
//   busy, done, s, co     : sequencer -> requester
// Modports: master (requester side), slave (sequencer side).

interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             clr;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             co;

    modport master (
        output start, clr, a, b, cin,
        input  busy, done, s, co
    );

    modport slave (
        input  start, clr, a, b, cin,
        output busy, done, s, co
    );
endinterface

// File: rtl/fa_bit.sv
// fa_bit
// 1-bit full adder built from two half adders and an OR, purely combinational.
// This is the single adder cell shared across every bit of the serial add.
//   a, b : addend bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out

module fa_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic s_ab;
    logic c_ab;
    logic c_sc;

    ha_bit u_ha_ab (
        .a  (a),
        .b  (b),
        .s  (s_ab),
        .co (c_ab)
    );

    ha_bit u_ha_sc (
        .a  (s_ab),
        .b  (ci),
        .s  (s),
        .co (c_sc)
    );

    // Both half-adder carries can never be 1 together, so OR is exact.
    assign co = c_ab | c_sc;
endmodule

// File: rtl/ha_bit.sv
// ha_bit
// 1-bit half adder, purely combinational.
//   a, b : addend bits
//   s    : sum bit
//   co   : carry out

module ha_bit (
    input  logic a,
    input  logic b,
    output logic s,
    output logic co
);
    assign s  = a ^ b;
    assign co = a & b;
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
// Bit-serial adder sequencer: captures a WIDTH-bit operand pair on start and
// feeds one bit pair per clock (LSB first) through a single shared full-adder
// cell, shifting the sum in from the MSB side. Result is held while done=1.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : serial_add_ctrl_if.slave (start/clr/a/b/cin in, busy/done/s/co out)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; outputs cleared
// RUN   | one bit pair added per clock; start ignored
// DONE  | s/co valid and held; start re-accepts a new operation

module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_add_ctrl_if.slave   bus
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] s_q;
    logic             carry_q;
    logic             co_q;

    logic             accept;
    logic             step;
    logic             clear;
    logic             last;
    logic             cell_s;
    logic             cell_co;

    fa_bit u_fa (
        .a  (a_sh_q[0]),
        .b  (b_sh_q[0]),
        .ci (carry_q),
        .s  (cell_s),
        .co (cell_co)
    );

    assign last = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        clear   = 1'b0;
        if (bus.clr) begin
            // Abort wins over a simultaneous start.
            state_d = S_IDLE;
            clear   = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        accept  = 1'b1;
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    step = 1'b1;
                    if (last) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.start) begin
                        accept  = 1'b1;
                        state_d = S_RUN;
                    end
                end
                default: begin
                    // Unused encoding behaves exactly like IDLE.
                    state_d = S_IDLE;
                    if (bus.start) begin
                        accept  = 1'b1;
                        state_d = S_RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
        end else if (clear) begin
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
        end else if (accept) begin
            cnt_q   <= '0;
            a_sh_q  <= bus.a;
            b_sh_q  <= bus.b;
            s_q     <= '0;
            carry_q <= bus.cin;
            co_q    <= 1'b0;
        end else if (step) begin
            cnt_q   <= cnt_q + 1'b1;
            a_sh_q  <= a_sh_q >> 1;
            b_sh_q  <= b_sh_q >> 1;
            // Sum enters at the MSB; written without a part-select so WIDTH=1 works.
            s_q     <= (s_q >> 1) | (WIDTH'(cell_s) << (WIDTH - 1));
            carry_q <= cell_co;
            if (last) begin
                co_q <= cell_co;
            end
        end
    end

    assign bus.busy = (state_q == S_RUN);
    assign bus.done = (state_q == S_DONE);
    assign bus.s    = s_q;
    assign bus.co   = co_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl
// Self-checking bench for serial_add_ctrl: an 8-bit instance exercised with
// directed and random operations, plus a 1-bit instance. Expected results
// come from plain integer addition of the captured operands.

module tb_serial_add_ctrl;

    logic clk;
    logic rst_n;

    int n_chk;
    int n_fail;

    serial_add_ctrl_if #(.WIDTH(8)) bus8 ();
    serial_add_ctrl_if #(.WIDTH(1)) bus1 ();

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] ref_add8(input logic [7:0] a, input logic [7:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + {8'd0, c};
    endfunction

    // mode 0: quiet; 1: random operand/start noise during RUN; 2: start re-pulse with a=0 at RUN cycle 3
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c, input int mode, input string tag);
        logic [8:0] exp;
        exp = ref_add8(a, b, c);
        bus8.a     = a;
        bus8.b     = b;
        bus8.cin   = c;
        bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        check({tag, " busy@0"}, 64'(bus8.busy), 64'd1);
        check({tag, " done@0"}, 64'(bus8.done), 64'd0);
        for (int k = 1; k < 8; k++) begin
            if (mode == 1) begin
                bus8.a     = 8'($urandom);
                bus8.b     = 8'($urandom);
                bus8.cin   = 1'($urandom);
                bus8.start = 1'($urandom_range(0, 1));
            end else if (mode == 2) begin
                bus8.start = (k == 3);
                if (k == 3) begin
                    bus8.a = 8'h00;
                    bus8.b = 8'h00;
                end
            end
            tick();
            check({tag, " busy"}, 64'(bus8.busy), 64'd1);
        end
        bus8.start = 1'b0;
        tick();
        check({tag, " done"}, 64'(bus8.done), 64'd1);
        check({tag, " busy end"}, 64'(bus8.busy), 64'd0);
        check({tag, " s"}, 64'(bus8.s), 64'(exp[7:0]));
        check({tag, " co"}, 64'(bus8.co), 64'(exp[8]));
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        logic [1:0] exp1;

        n_chk  = 0;
        n_fail = 0;
        bus8.start = 1'b0; bus8.clr = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
        bus1.start = 1'b0; bus1.clr = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("reset busy", 64'(bus8.busy), 64'd0);
        check("reset done", 64'(bus8.done), 64'd0);
        check("reset s", 64'(bus8.s), 64'd0);
        check("reset co", 64'(bus8.co), 64'd0);
        #10 rst_n = 1'b1;
        tick();
        check("idle busy", 64'(bus8.busy), 64'd0);
        check("idle done", 64'(bus8.done), 64'd0);

        run8(8'h5A, 8'h3C, 1'b0, 0, "5a+3c");
        check("5a+3c s const", 64'(bus8.s), 64'h96);
        tick();
        check("done hold", 64'(bus8.done), 64'd1);
        check("done hold s", 64'(bus8.s), 64'h96);

        run8(8'hFF, 8'h01, 1'b0, 0, "ff+01");
        run8(8'hFF, 8'hFF, 1'b1, 0, "ff+ff+1");
        run8(8'h5A, 8'h3C, 1'b0, 2, "repulse");

        for (int i = 0; i < 12; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            run8(ra, rb, rc, 1, "rand");
        end

        // start held high from DONE through the whole run
        bus8.a = 8'h01; bus8.b = 8'h01; bus8.cin = 1'b0; bus8.start = 1'b1;
        tick();
        check("held done drop", 64'(bus8.done), 64'd0);
        check("held busy", 64'(bus8.busy), 64'd1);
        for (int k = 1; k < 8; k++) tick();
        check("held busy last", 64'(bus8.busy), 64'd1);
        tick();
        check("held done", 64'(bus8.done), 64'd1);
        check("held s", 64'(bus8.s), 64'h02);
        check("held co", 64'(bus8.co), 64'd0);
        bus8.start = 1'b0;
        tick();
        check("held stay done", 64'(bus8.done), 64'd1);

        // clr from DONE
        bus8.clr = 1'b1;
        tick();
        bus8.clr = 1'b0;
        check("clr done", 64'(bus8.done), 64'd0);
        check("clr s", 64'(bus8.s), 64'd0);
        check("clr co", 64'(bus8.co), 64'd0);

        // clr and start together in IDLE
        bus8.clr = 1'b1; bus8.start = 1'b1; bus8.a = 8'h12; bus8.b = 8'h34;
        tick();
        bus8.clr = 1'b0; bus8.start = 1'b0;
        check("clr+start busy", 64'(bus8.busy), 64'd0);
        check("clr+start done", 64'(bus8.done), 64'd0);
        tick();
        check("clr+start stay", 64'(bus8.busy), 64'd0);

        // clr mid-RUN
        bus8.a = 8'hC3; bus8.b = 8'h5F; bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        tick(); tick(); tick();
        bus8.clr = 1'b1;
        tick();
        bus8.clr = 1'b0;
        check("clr run busy", 64'(bus8.busy), 64'd0);
        check("clr run s", 64'(bus8.s), 64'd0);
        run8(8'hC3, 8'h5F, 1'b1, 0, "after clr");

        // asynchronous reset at RUN cycle 4
        bus8.a = 8'h5A; bus8.b = 8'h3C; bus8.cin = 1'b0; bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        tick(); tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst busy", 64'(bus8.busy), 64'd0);
        check("arst done", 64'(bus8.done), 64'd0);
        check("arst s", 64'(bus8.s), 64'd0);
        check("arst co", 64'(bus8.co), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("arst idle busy", 64'(bus8.busy), 64'd0);
        check("arst idle done", 64'(bus8.done), 64'd0);

        // WIDTH=1 instance: every operand combination
        for (int v = 7; v >= 0; v--) begin
            bus1.a     = 1'(v >> 2);
            bus1.b     = 1'(v >> 1);
            bus1.cin   = 1'(v);
            exp1       = 2'(v >> 2) + 2'((v >> 1) & 1) + 2'(v & 1);
            bus1.start = 1'b1;
            tick();
            bus1.start = 1'b0;
            check("w1 busy", 64'(bus1.busy), 64'd1);
            check("w1 done@0", 64'(bus1.done), 64'd0);
            tick();
            check("w1 done", 64'(bus1.done), 64'd1);
            check("w1 s", 64'(bus1.s), 64'(exp1[0]));
            check("w1 co", 64'(bus1.co), 64'(exp1[1]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
